nibble_serial_subtractor: RTL

Multi-cycle two's-complement subtractor that computes `a - b` one 4-bit slice per clock, with the inter-slice carry held in a register. It complements the combinational 4-bit carry look-ahead adder used in the arithmetic datapath. It reuses a single 4-bit add slice (`a_nib + ~b_nib + c`) instead of a full-width combinational chain. A start/ready/done handshake lets a controller FSM issue subtractions and collect difference and flags.

---
 rtl/nibble_serial_subtractor_if.sv | 25 ++
 rtl/nibble_serial_subtractor.sv | 114 +++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor_if.sv
// Handshake and operand/result bundle for the nibble-serial subtractor.
// The master issues operands; the slave returns difference and flags.
interface nibble_serial_subtractor_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             overflow;
   logic             zero;

   modport master (
      output start, a, b,
      input  ready, done, diff, borrow, overflow, zero
   );

   modport slave (
      input  start, a, b,
      output ready, done, diff, borrow, overflow, zero
   );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Two's-complement a - b, one 4-bit slice per clock through a single
// a + ~b + c adder slice with the inter-slice carry held in a register.
module nibble_serial_subtractor #(
   parameter int WIDTH = 16
) (
   input  logic clk,
   input  logic rst_n,
   nibble_serial_subtractor_if.slave sub_if
);
   localparam int N   = WIDTH / 4;
   localparam int IW  = (N > 1) ? $clog2(N) : 1;
   localparam int MSB = WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [4:0]       sum;
   logic             accept;

   always_comb begin
      a_sh   = a_q >> {idx_q, 2'b00};
      b_sh   = b_q >> {idx_q, 2'b00};
      sum    = {1'b0, a_sh[3:0]} + {1'b0, ~b_sh[3:0]} + {4'b0, carry_q};
      accept = sub_if.start && (state_q != RUN);

      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;

      unique case (state_q)
         IDLE: begin
            if (sub_if.start) state_d = RUN;
         end
         RUN: begin
            for (int i = 0; i < N; i++) begin
               if (idx_q == IW'(i)) diff_d[i*4 +: 4] = sum[3:0];
            end
            carry_d = sum[4];
            idx_d   = idx_q + 1'b1;
            // Flags are taken from the fully assembled result only.
            if (idx_q == IW'(N - 1)) begin
               state_d  = DONE;
               borrow_d = ~sum[4];
               ovf_d    = (a_q[MSB] != b_q[MSB]) &&
                          (diff_d[MSB] != a_q[MSB]);
               zero_d   = (diff_d == '0);
            end
         end
         DONE: begin
            state_d = sub_if.start ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         a_d     = sub_if.a;
         b_d     = sub_if.b;
         carry_d = 1'b1;
         idx_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign sub_if.ready    = (state_q != RUN);
   assign sub_if.done     = (state_q == DONE);
   assign sub_if.diff     = diff_q;
   assign sub_if.borrow   = borrow_q;
   assign sub_if.overflow = ovf_q;
   assign sub_if.zero     = zero_q;
endmodule
